// File: rtl/bus_master_port.sv
// bus_master_port: per-master front end; requests the bus, serialises mode/address/write data LSB-first, deserialises read data.
// Latency: breq rises 1 cycle after command accept, first bit 1 cycle after bgrant sampled, ack 1 cycle after sready sampled in DONE.
// Backpressure: dready low while busy; waits on bgrant (REQ), svalid (read), sready (DONE). Define MASTER_TIMEOUT_EN for read-wait abort with terr.
module bus_master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ack,
  output logic                  terr,
  output logic                  breq,
  input  logic                  bgrant,
  output logic                  mout,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  sin,
  input  logic                  svalid,
  input  logic                  sready
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WDATA, S_RDATA, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  // Holds write data on writes; reused as the receive shift register on reads.
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   drdata_q, drdata_d;
  logic [DATA_WIDTH-1:0]   rx_shift;
  logic                    mode_q, mode_d;
  logic                    dready_q, dready_d;
  logic                    ack_q, ack_d;
  logic                    breq_q, breq_d;
  logic                    mout_q, mout_d;
  logic                    mmode_q, mmode_d;
  logic                    mvalid_q, mvalid_d;
  logic                    grant_lost;

`ifdef MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tflag_q, tflag_d;
  logic          terr_q, terr_d;
  assign terr = terr_q;
`else
  assign terr = 1'b0;
`endif

  assign dready = dready_q;
  assign drdata = drdata_q;
  assign ack    = ack_q;
  assign breq   = breq_q;
  assign mout   = mout_q;
  assign mmode  = mmode_q;
  assign mvalid = mvalid_q;

  // Next-state and registered-output computation; serial bits come from shifting the captured words right.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    mode_d   = mode_q;
    dready_d = dready_q;
    drdata_d = drdata_q;
    breq_d   = breq_q;
    ack_d    = 1'b0;
    mvalid_d = 1'b0;
    mout_d   = 1'b0;
    mmode_d  = 1'b0;
    rx_shift = {sin, data_q[DATA_WIDTH-1:1]};
    grant_lost = !bgrant && (state_q == S_ADDR || state_q == S_WDATA || state_q == S_RDATA);
`ifdef MASTER_TIMEOUT_EN
    tmo_d   = tmo_q;
    tflag_d = tflag_q;
    terr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (dvalid) begin
          addr_d   = daddr;
          data_d   = dwdata;
          mode_d   = dmode;
          cnt_d    = '0;
          dready_d = 1'b0;
          breq_d   = 1'b1;
          state_d  = S_REQ;
`ifdef MASTER_TIMEOUT_EN
          tflag_d  = 1'b0;
`endif
        end
      end
      S_REQ: begin
        if (bgrant) begin
          state_d  = S_ADDR;
          cnt_d    = '0;
          mvalid_d = 1'b1;
          mmode_d  = mode_q;
          mout_d   = addr_q[0];
          addr_d   = addr_q >> 1;
        end
      end
      S_ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          cnt_d = '0;
          if (mode_q) begin
            state_d  = S_WDATA;
            mvalid_d = 1'b1;
            mmode_d  = 1'b1;
            mout_d   = data_q[0];
            data_d   = data_q >> 1;
          end else begin
            state_d  = S_RDATA;
`ifdef MASTER_TIMEOUT_EN
            tmo_d    = '0;
`endif
          end
        end else begin
          cnt_d    = cnt_q + 1'b1;
          mvalid_d = 1'b1;
          mmode_d  = mode_q;
          mout_d   = addr_q[0];
          addr_d   = addr_q >> 1;
        end
      end
      S_WDATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          breq_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          mvalid_d = 1'b1;
          mmode_d  = 1'b1;
          mout_d   = data_q[0];
          data_d   = data_q >> 1;
        end
      end
      S_RDATA: begin
        if (svalid) begin
          data_d = rx_shift;
`ifdef MASTER_TIMEOUT_EN
          tmo_d  = '0;
`endif
          if (cnt_q == DATA_LAST) begin
            cnt_d    = '0;
            breq_d   = 1'b0;
            drdata_d = rx_shift;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          cnt_d    = '0;
          tmo_d    = '0;
          breq_d   = 1'b0;
          drdata_d = '1;
          tflag_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        if (sready) begin
          ack_d    = 1'b1;
          dready_d = 1'b1;
          state_d  = S_IDLE;
`ifdef MASTER_TIMEOUT_EN
          terr_d   = tflag_q;
          tflag_d  = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Arbiter dropped grant mid-transfer: abandon silently, keep last read data.
    if (grant_lost) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      breq_d   = 1'b0;
      dready_d = 1'b1;
      drdata_d = drdata_q;
      mvalid_d = 1'b0;
      mout_d   = 1'b0;
      mmode_d  = 1'b0;
`ifdef MASTER_TIMEOUT_EN
      tmo_d    = '0;
      tflag_d  = 1'b0;
`endif
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      drdata_q <= '0;
      mode_q   <= 1'b0;
      dready_q <= 1'b1;
      ack_q    <= 1'b0;
      breq_q   <= 1'b0;
      mout_q   <= 1'b0;
      mmode_q  <= 1'b0;
      mvalid_q <= 1'b0;
`ifdef MASTER_TIMEOUT_EN
      tmo_q    <= '0;
      tflag_q  <= 1'b0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      drdata_q <= drdata_d;
      mode_q   <= mode_d;
      dready_q <= dready_d;
      ack_q    <= ack_d;
      breq_q   <= breq_d;
      mout_q   <= mout_d;
      mmode_q  <= mmode_d;
      mvalid_q <= mvalid_d;
`ifdef MASTER_TIMEOUT_EN
      tmo_q    <= tmo_d;
      tflag_q  <= tflag_d;
      terr_q   <= terr_d;
`endif
    end
  end

endmodule
